// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
// Holds the FSM state encoding, access-size codes and the alignment check.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Bit of the 3-bit size field that selects zero-extension on loads.
  localparam int SZ_UNSIGNED_BIT = 2;

  function automatic logic access_err(input logic [2:0] size, input logic [1:0] addr_lo);
    logic err;
    case (size[1:0])
      SZ_B:    err = 1'b0;
      SZ_H:    err = addr_lo[0];
      SZ_W:    err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way grant picker: a lone requester always wins, the pointer
// breaks ties when both requesters are valid.
module dmem_rr_pick (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter, one transaction in flight, fixed 2-cycle latency.
// Define DMEM_ARBITER_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int A_WIDTH = 20
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req0_we,
  input  logic [2:0]  req0_size,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic        req1_we,
  input  logic [2:0]  req1_size,

  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,

  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,

  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic [2:0]  mem_src,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] A_MASK = (A_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                   : ((32'd1 << A_WIDTH) - 32'd1);

  state_t      state;
  logic        armed;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_we;
  logic [2:0]  lat_size;
  logic        lat_port;
  logic        lat_err;
  logic        ptr;
  logic [1:0]  grant;
  logic        hs0;
  logic        hs1;
  logic [31:0] rsp_data_next;

  dmem_rr_pick u_pick (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ptr    (ptr),
    .grant  (grant)
  );

  // armed keeps ready low until the first clock edge after reset release.
  assign req0_ready = (state == IDLE) && armed && grant[0];
  assign req1_ready = (state == IDLE) && armed && grant[1];
  assign hs0 = req0_valid && req0_ready;
  assign hs1 = req1_valid && req1_ready;

`ifdef DMEM_ARBITER_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if ((hs0 || hs1) && req0_valid && req1_valid) begin
      ptr <= ~ptr;
    end
  end
`else
  assign ptr = 1'b0;
`endif

  always_comb begin
    mem_a   = '0;
    mem_wd  = '0;
    mem_src = '0;
    mem_we  = 1'b0;
    if (state == ACCESS) begin
      mem_a   = lat_addr & A_MASK;
      mem_wd  = lat_wdata;
      mem_src = {lat_size[SZ_UNSIGNED_BIT], lat_size[1:0]};
      mem_we  = lat_we && !lat_err;
    end
  end

  // Stores and faulting accesses report zero read data.
  assign rsp_data_next = (lat_we || lat_err) ? 32'h0 : mem_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
      lat_size   <= '0;
      lat_port   <= 1'b0;
      lat_err    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (hs1) begin
            lat_addr  <= req1_addr;
            lat_wdata <= req1_wdata;
            lat_we    <= req1_we;
            lat_size  <= req1_size;
            lat_port  <= 1'b1;
            lat_err   <= access_err(req1_size, req1_addr[1:0]);
            state     <= ACCESS;
          end else if (hs0) begin
            lat_addr  <= req0_addr;
            lat_wdata <= req0_wdata;
            lat_we    <= req0_we;
            lat_size  <= req0_size;
            lat_port  <= 1'b0;
            lat_err   <= access_err(req0_size, req0_addr[1:0]);
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_port) begin
            rsp1_valid <= 1'b1;
            rsp1_rdata <= rsp_data_next;
            rsp1_err   <= lat_err;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_rdata <= rsp_data_next;
            rsp0_err   <= lat_err;
          end
          state <= RESP;
        end
        RESP: begin
          rsp0_valid <= 1'b0;
          rsp0_err   <= 1'b0;
          rsp1_valid <= 1'b0;
          rsp1_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-addressed memory model.
// Expected grant order follows DMEM_ARBITER_RR_EN when defined.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic [2:0]  req0_size;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wdata;
  logic [2:0]  req1_size;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
  logic [2:0]  mem_src;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  size;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_cyc = -100;
  logic we_seen = 1'b0;
  bit [7:0] mem_arr [0:1048575];

  dmem_arbiter #(.A_WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_we(req0_we), .req0_size(req0_size),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_we(req1_we), .req1_size(req1_size),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_src(mem_src), .mem_rd(mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Little-endian memory; sub-word loads are extended according to the size code.
  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] src);
    logic [19:0] i;
    logic [7:0]  b;
    logic [15:0] h;
    i = a[19:0];
    b = mem_arr[i];
    h = {mem_arr[i + 20'd1], mem_arr[i]};
    case (src[1:0])
      2'b00:   return src[SZ_UNSIGNED_BIT] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return src[SZ_UNSIGNED_BIT] ? {16'h0, h} : {{16{h[15]}}, h};
      default: return {mem_arr[i + 20'd3], mem_arr[i + 20'd2], h};
    endcase
  endfunction

  assign mem_rd = mem_read(mem_a, mem_src);

  always @(posedge clk) begin
    if (mem_we) begin
      mem_arr[mem_a[19:0]] <= mem_wd[7:0];
      if (mem_src[1:0] != 2'b00) mem_arr[mem_a[19:0] + 20'd1] <= mem_wd[15:8];
      if (mem_src[1:0] == 2'b10) begin
        mem_arr[mem_a[19:0] + 20'd2] <= mem_wd[23:16];
        mem_arr[mem_a[19:0] + 20'd3] <= mem_wd[31:24];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: handshake order, memory-side view during ACCESS, response contents and latency.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_we) we_seen = 1'b1;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        checkOutput("hs_spacing", 32'((cyc - hs_cyc) >= 3), 32'd1);
        hs_cyc = cyc;
        if (sb.size() == 0) checkOutput("hs_unexpected", 32'd1, 32'd0);
        else checkOutput("grant_port", {31'b0, req1_valid && req1_ready}, sb[0].port);
      end
      if (cyc == hs_cyc + 1 && sb.size() > 0) begin
        checkOutput("mem_a", mem_a, sb[0].addr);
        checkOutput("mem_src", {29'b0, mem_src}, {29'b0, sb[0].size});
        checkOutput("mem_we", {31'b0, mem_we}, {31'b0, sb[0].we && !sb[0].err});
        if (sb[0].we && !sb[0].err) checkOutput("mem_wd", mem_wd, sb[0].wdata);
      end
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          checkOutput("rsp_spurious", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_port", {30'b0, rsp1_valid, rsp0_valid}, (e.port == 1) ? 32'd2 : 32'd1);
          checkOutput("rsp_rdata", (e.port == 1) ? rsp1_rdata : rsp0_rdata, e.rdata);
          checkOutput("rsp_err", {31'b0, (e.port == 1) ? rsp1_err : rsp0_err}, {31'b0, e.err});
          checkOutput("rsp_latency", cyc - hs_cyc, 32'd2);
          checkOutput("idle_mem", {mem_a[30:0], mem_we}, 32'd0);
        end
      end
    end
  end

  task automatic setReq(input int port, input logic v, input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic [2:0] sz);
    if (port == 0) begin
      req0_valid = v; req0_addr = a; req0_wdata = wd; req0_we = we; req0_size = sz;
    end else begin
      req1_valid = v; req1_addr = a; req1_wdata = wd; req1_we = we; req1_size = sz;
    end
  endtask

  function automatic exp_t mkExp(input int port, input logic [31:0] a, input logic [31:0] wd,
                                 input logic we, input logic [2:0] sz,
                                 input logic [31:0] rd, input logic err);
    exp_t e;
    e.port = port; e.addr = a; e.wdata = wd; e.we = we; e.size = sz; e.rdata = rd; e.err = err;
    return e;
  endfunction

  // Drives one request and returns one time unit into the ACCESS cycle.
  task automatic applyStimulus(input int port, input logic [31:0] a, input logic [31:0] wd,
                               input logic we, input logic [2:0] sz,
                               input logic [31:0] rd, input logic err);
    logic got;
    got = 1'b0;
    sb.push_back(mkExp(port, a, wd, we, sz, rd, err));
    @(posedge clk); #1;
    setReq(port, 1'b1, a, wd, we, sz);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    setReq(port, 1'b0, 32'h0, 32'h0, 1'b0, 3'b0);
    if (!got) begin
      checkOutput("hs_timeout", 32'd0, 32'd1);
      void'(sb.pop_back());
    end
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checkOutput("rsp_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic doOp(input int port, input logic [31:0] a, input logic [31:0] wd,
                      input logic we, input logic [2:0] sz,
                      input logic [31:0] rd, input logic err);
    applyStimulus(port, a, wd, we, sz, rd, err);
    waitIdle();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int g;
    exp_t e0;
    exp_t e1;
    rst_n = 1'b0;
    setReq(0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b0);
    setReq(1, 1'b0, 32'h0, 32'h0, 1'b0, 3'b0);
    #12;
    req0_valid = 1'b1;
    #1;
    checkOutput("rst_ready0", {31'b0, req0_ready}, 32'd0);
    checkOutput("rst_rsp", {29'b0, rsp0_valid, rsp1_valid, mem_we}, 32'd0);
    checkOutput("rst_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    doOp(0, 32'h0001_0000, 32'hDEAD_BEEF, 1'b1, 3'b010, 32'h0, 1'b0);
    applyStimulus(0, 32'h0001_0000, 32'h0, 1'b0, 3'b010, 32'hDEAD_BEEF, 1'b0);
    req1_valid = 1'b1;
    #1;
    checkOutput("busy_ready_access", {31'b0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("busy_ready_resp", {31'b0, req1_ready}, 32'd0);
    req1_valid = 1'b0;
    waitIdle();

    doOp(1, 32'h80, 32'h0000_0080, 1'b1, 3'b000, 32'h0, 1'b0);
    doOp(1, 32'h80, 32'h0, 1'b0, 3'b000, 32'hFFFF_FF80, 1'b0);
    doOp(1, 32'h80, 32'h0, 1'b0, 3'b100, 32'h0000_0080, 1'b0);

    e0 = mkExp(0, 32'h0001_0000, 32'h0, 1'b0, 3'b010, 32'hDEAD_BEEF, 1'b0);
    e1 = mkExp(1, 32'h80, 32'h0, 1'b0, 3'b100, 32'h0000_0080, 1'b0);
`ifdef DMEM_ARBITER_RR_EN
    sb.push_back(e0); sb.push_back(e1); sb.push_back(e0); sb.push_back(e1);
`else
    sb.push_back(e0); sb.push_back(e0); sb.push_back(e0); sb.push_back(e0);
`endif
    @(posedge clk); #1;
    setReq(0, 1'b1, e0.addr, 32'h0, 1'b0, e0.size);
    setReq(1, 1'b1, e1.addr, 32'h0, 1'b0, e1.size);
    g = 0;
    for (int i = 0; i < 40 && g < 4; i++) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) g++;
    end
    @(posedge clk); #1;
    setReq(0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b0);
    setReq(1, 1'b0, 32'h0, 32'h0, 1'b0, 3'b0);
    checkOutput("contend_grants", g, 32'd4);
    waitIdle();

    we_seen = 1'b0;
    doOp(0, 32'h0001_0002, 32'h1122_3344, 1'b1, 3'b010, 32'h0, 1'b1);
    checkOutput("misalign_no_we", {31'b0, we_seen}, 32'd0);
    checkOutput("misalign_mem", mem_read(32'h0001_0000, 3'b010), 32'hDEAD_BEEF);
    doOp(1, 32'h0, 32'h0, 1'b0, 3'b011, 32'h0, 1'b1);
    doOp(0, 32'h301, 32'h0, 1'b0, 3'b101, 32'h0, 1'b1);

    doOp(1, 32'h302, 32'h0000_005A, 1'b1, 3'b000, 32'h0, 1'b0);
    doOp(0, 32'h300, 32'h0000_ABCD, 1'b1, 3'b001, 32'h0, 1'b0);
    doOp(0, 32'h300, 32'h0, 1'b0, 3'b101, 32'h0000_ABCD, 1'b0);
    doOp(1, 32'h300, 32'h0, 1'b0, 3'b001, 32'hFFFF_ABCD, 1'b0);
    doOp(0, 32'h302, 32'h0, 1'b0, 3'b100, 32'h0000_005A, 1'b0);
    checkOutput("half_neighbour", {24'h0, mem_arr[20'h302]}, 32'h5A);

    we_seen = 1'b0;
    applyStimulus(0, 32'h200, 32'h1234_5678, 1'b1, 3'b010, 32'h0, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    req1_valid = 1'b1;
    #1;
    checkOutput("rst_abort_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_abort_ready", {31'b0, req1_ready}, 32'd0);
    checkOutput("rst_abort_rdata", rsp0_rdata, 32'd0);
    repeat (2) @(negedge clk);
    req1_valid = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_abort_nowrite", {31'b0, we_seen}, 32'd0);
    checkOutput("rst_abort_mem", mem_read(32'h200, 3'b010), 32'h0);
    doOp(0, 32'h200, 32'h0, 1'b0, 3'b010, 32'h0, 1'b0);
    doOp(1, 32'h0001_0000, 32'h0, 1'b0, 3'b010, 32'hDEAD_BEEF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter A_WIDTH, default 20, meaning data-memory byte-address width passed through to the memory side.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have, for each requester n in {0,1}, ports reqn_valid in 1, reqn_ready out 1, reqn_addr in 32, reqn_wdata in 32, reqn_we in 1, reqn_size in 3 (bit2 = unsigned, [1:0] 00 byte / 01 half / 10 word).
REQ-005 SHALL have, for each n, ports rspn_valid out 1, rspn_rdata out 32, rspn_err out 1.
REQ-006 SHALL have memory-side ports mem_a out 32, mem_wd out 32, mem_we out 1, mem_src out 3, mem_rd in 32 (combinational read, write on clk edge).

Function
REQ-007 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; exactly one transaction in flight.
REQ-008 In IDLE, reqn_ready SHALL be 1 only for the granted port, combinationally; handshake = valid && ready.
REQ-009 On handshake, addr/wdata/we/size and port id SHALL be latched; FSM -> ACCESS next cycle.
REQ-010 In ACCESS, mem_a/mem_wd/mem_src SHALL come from latched fields; mem_we = latched we && !err for that cycle only; mem_rd captured into response register.
REQ-011 In RESP, rspn_valid SHALL pulse 1 cycle for the latched port only; rdata = captured mem_rd for loads, 0 for stores.
REQ-012 Latency SHALL be fixed: handshake in cycle T -> rsp_valid in T+2; next handshake no earlier than T+3.
REQ-013 Outside ACCESS, mem_we SHALL be 0 and mem_a/mem_wd/mem_src SHALL be 0.
REQ-014 err SHALL be set for size[1:0]=11, half with addr[0]=1, word with addr[1:0]!=0; erroneous store never writes; erroneous load returns rdata 0.
REQ-015 Only one port valid: that port SHALL be granted regardless of arbitration pointer.
REQ-016 Both valid: winner SHALL follow REQ-023 (macro set) or REQ-024 (macro unset).
REQ-017 reqn_valid dropped without handshake SHALL have no effect; request fields sampled only at handshake.
REQ-018 Requests outside IDLE SHALL see ready=0 and be held by the requester.

Reset
REQ-019 rst_n=0 SHALL asynchronously force IDLE, all ready/rsp_valid/rsp_err/mem_we to 0, rdata registers to 0, RR pointer to port 0.
REQ-020 Reset during ACCESS SHALL abort the transaction: no memory write, no response after release.
REQ-021 First grant after reset SHALL be no earlier than the first rising edge with rst_n=1.

Configuration
REQ-022 Macro DMEM_ARBITER_RR_EN SHALL select arbitration policy.
REQ-023 Defined: round-robin; on contention grant the port indicated by the pointer; pointer toggles to the other port after every granted contention.
REQ-024 Undefined: fixed priority, port 0 always wins contention; pointer logic absent.

Structure
REQ-025 Package dmem_arb_pkg SHALL hold state enum (IDLE/ACCESS/RESP), size codes (SZ_B=00, SZ_H=01, SZ_W=10), unsigned bit index.
REQ-026 Grant selection SHALL be sub-module dmem_rr_pick (inputs 2 valids + pointer, outputs one-hot grant).
REQ-027 Implementation SHALL be a single top plus dmem_rr_pick, no other hierarchy.

Verification
REQ-028 Port0 store word 0xDEADBEEF at 0x10000, then load word -> rsp0_rdata=0xDEADBEEF, err=0, rsp at T+2 each.
REQ-029 Port1 load byte signed (size 000) at byte 0x80 -> 0xFFFFFF80; size 100 -> 0x00000080.
REQ-030 Both valid every cycle for 4 grants: RR_EN -> order 0,1,0,1; no macro -> 0,0,0,0.
REQ-031 Port0 word store at 0x10002 -> rsp0_err=1, mem_we never 1, memory unchanged.
REQ-032 Assert rst_n=0 in ACCESS of a store 0x12345678 to 0x200 -> no write, no rsp_valid, FSM IDLE.
REQ-033 Half store 0xABCD at 0x300 then load half unsigned -> 0x0000ABCD; neighbour byte 0x302 unchanged.
